ahb_mem_responder: RTL

AHB-Lite slave memory that answers the DMA master port (MAddress/MWData/MWStrb/MTrans/MWrite), returning read data, HReady and a 2-bit HResp. It acts as the transfer target the DMAC channels read from and write to, for both integration and channel-level verification. It has word-organised storage, byte-strobed writes, optional wait-state insertion and an ERROR response for out-of-range addresses.

---
 rtl/ahb_mem_responder_if.sv | 22 ++
 rtl/ahb_mem_responder.sv | 131 +++++++++++++
 2 files changed

// File: rtl/ahb_mem_responder_if.sv
// AHB-Lite bus bundle between a DMA master port and the ahb_mem_responder target.
interface ahb_mem_responder_if;
    logic        HSel;
    logic [31:0] HAddr;
    logic [1:0]  HTrans;
    logic        HWrite;
    logic [31:0] HWData;
    logic [3:0]  HWStrb;
    logic [31:0] HRData;
    logic        HReady;
    logic [1:0]  HResp;

    modport master (
        output HSel, HAddr, HTrans, HWrite, HWData, HWStrb,
        input  HRData, HReady, HResp
    );

    modport slave (
        input  HSel, HAddr, HTrans, HWrite, HWData, HWStrb,
        output HRData, HReady, HResp
    );
endinterface

// File: rtl/ahb_mem_responder.sv
// AHB-Lite word memory target: byte-strobed writes, read-after-write forwarding, ERROR beyond DEPTH.
// Defining AHB_MEM_WAIT_EN stretches every in-range data phase by WAIT_CYCLES wait states.
module ahb_mem_responder #(
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst,
    ahb_mem_responder_if.slave bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

`ifdef AHB_MEM_WAIT_EN
    typedef enum logic [2:0] {ST_IDLE, ST_DATA, ST_WAIT, ST_ERR1, ST_ERR2} state_t;
    logic [3:0] cnt_q, cnt_d;
`else
    typedef enum logic [2:0] {ST_IDLE, ST_DATA, ST_ERR1, ST_ERR2} state_t;
`endif

    state_t        state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic          write_q, write_d;
    logic          hready_q, hready_d;
    logic [1:0]    hresp_q, hresp_d;
    logic [31:0]   rdata_q, rdata_d;
    logic [31:0]   mem [DEPTH];

    logic          accept, new_oor, commit, stall;
    logic [AW-1:0] new_idx;
    logic [31:0]   merged;
    logic          unused_bits;

    assign unused_bits = &{1'b0, bus.HAddr[1:0], bus.HTrans[0]};

    always_comb begin
        new_idx = bus.HAddr[AW+1:2];
        new_oor = {2'b00, bus.HAddr[31:2]} >= 32'(DEPTH);
        accept  = bus.HSel && bus.HTrans[1] && hready_q;
        commit  = (state_q == ST_DATA) && write_q;
        // Word as it will look once the write in its DATA cycle commits
        merged  = mem[idx_q];
        for (int i = 0; i < 4; i++) begin
            if (bus.HWStrb[i]) merged[8*i +: 8] = bus.HWData[8*i +: 8];
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        write_d = write_q;
`ifdef AHB_MEM_WAIT_EN
        cnt_d   = cnt_q;
`endif
        if (accept) begin
            idx_d   = new_idx;
            write_d = bus.HWrite;
            if (new_oor) begin
                state_d = ST_ERR1;
`ifdef AHB_MEM_WAIT_EN
            end else if (WAIT_CYCLES > 0) begin
                state_d = ST_WAIT;
                cnt_d   = 4'(WAIT_CYCLES - 1);
`endif
            end else begin
                state_d = ST_DATA;
            end
        end else begin
            case (state_q)
                ST_ERR1: state_d = ST_ERR2;
`ifdef AHB_MEM_WAIT_EN
                ST_WAIT: begin
                    if (cnt_q == 4'd0) state_d = ST_DATA;
                    else               cnt_d   = cnt_q - 4'd1;
                end
`endif
                default: state_d = ST_IDLE;
            endcase
        end

        stall = (state_d == ST_ERR1);
`ifdef AHB_MEM_WAIT_EN
        stall = stall || (state_d == ST_WAIT);
`endif
        hready_d = !stall;
        hresp_d  = ((state_d == ST_ERR1) || (state_d == ST_ERR2)) ? 2'b01 : 2'b00;

        // Read data is registered on entry to DATA so it is stable for the whole cycle
        rdata_d = rdata_q;
        if ((state_d == ST_DATA) && !write_d) begin
            if (!accept)                          rdata_d = mem[idx_q];
            else if (commit && (idx_q == new_idx)) rdata_d = merged;
            else                                  rdata_d = mem[new_idx];
        end
    end

    always_ff @(posedge clk) begin
        idx_q <= idx_d;
        if (rst) begin
            state_q  <= ST_IDLE;
            write_q  <= 1'b0;
            hready_q <= 1'b1;
            hresp_q  <= 2'b00;
            rdata_q  <= 32'd0;
`ifdef AHB_MEM_WAIT_EN
            cnt_q    <= 4'd0;
`endif
        end else begin
            state_q  <= state_d;
            write_q  <= write_d;
            hready_q <= hready_d;
            hresp_q  <= hresp_d;
            rdata_q  <= rdata_d;
`ifdef AHB_MEM_WAIT_EN
            cnt_q    <= cnt_d;
`endif
        end
    end

    // Storage survives reset; a write still pending when reset hits is dropped
    always_ff @(posedge clk) begin
        if (!rst && commit) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.HWStrb[i]) mem[idx_q][8*i +: 8] <= bus.HWData[8*i +: 8];
            end
        end
    end

    assign bus.HReady = hready_q;
    assign bus.HResp  = hresp_q;
    assign bus.HRData = rdata_q;
endmodule
